// File: rtl/stopwatch_seg_src_pkg.sv
// Shared definitions for the MM.SS.CC stopwatch feeding the 6-digit 74HC595 display driver.
// Holds the FSM state encodings, the display decimal-point pattern and the packing helper.
package stopwatch_seg_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // Dots after the MM and SS digit pairs; bit0 is the rightmost digit.
    localparam logic [5:0] POINT_MMSSCC = 6'b010100;
    localparam int         TICK_CNT_DEF = 500_000;

    function automatic logic [19:0] mmsscc_value(input logic [6:0] m,
                                                 input logic [5:0] s,
                                                 input logic [6:0] c);
        return 20'(m) * 20'd10000 + 20'(s) * 20'd100 + 20'(c);
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// 10 ms prescaler: counts only while enabled, holds its fraction when disabled,
// and emits a one-cycle tick on the cycle it wraps.
module stopwatch_tick_gen #(
    parameter int TICK_CNT = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_CNT - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_seg_src.sv
// Stopwatch top: run/pause/lap FSM, MM.SS.CC counters, lap freeze register and the
// registered data/point/seg_en/running outputs for the dynamic display driver.
module stopwatch_seg_src
    import stopwatch_seg_src_pkg::*;
#(
    parameter int TICK_CNT = TICK_CNT_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        running
);

    sw_state_e   state, state_nxt;
    logic [6:0]  cc, mm;
    logic [5:0]  ss;
    logic [19:0] lap_reg, live;
    logic        counting, tick, lap_cap;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign live     = mmsscc_value(mm, ss, cc);
    assign sign     = 1'b0;

    stopwatch_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (counting),
        .clr   (clear),
        .tick  (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // clear beats start_stop, which beats lap.
    always_comb begin
        state_nxt = state;
        lap_cap   = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_stop) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (start_stop) begin
                        state_nxt = ST_PAUSE;
                    end else if (lap) begin
                        state_nxt = ST_LAP;
                        lap_cap   = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (start_stop)  state_nxt = ST_PAUSE;
                    else if (lap)    state_nxt = ST_RUN;
                end
                ST_PAUSE: if (start_stop) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cc <= '0;
            ss <= '0;
            mm <= '0;
        end else if (clear) begin
            cc <= '0;
            ss <= '0;
            mm <= '0;
        end else if (tick) begin
            if (cc == 7'd99) begin
                cc <= '0;
                if (ss == 6'd59) begin
                    ss <= '0;
                    mm <= (mm == 7'd99) ? 7'd0 : mm + 7'd1;
                end else begin
                    ss <= ss + 6'd1;
                end
            end else begin
                cc <= cc + 7'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   lap_reg <= '0;
        else if (clear)   lap_reg <= '0;
        else if (lap_cap) lap_reg <= live;
    end

    // Display shows the frozen lap value only while in LAP; counting continues underneath.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data    <= '0;
            point   <= '0;
            seg_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            data    <= (state == ST_LAP) ? lap_reg : live;
            point   <= POINT_MMSSCC;
            seg_en  <= 1'b1;
            running <= counting;
        end
    end

endmodule
